// File: rtl/rgb_fader.sv
// Hue-cycling RGB fader: a prescaled tick walks one channel at a time around the colour wheel.
// Optional output gamma stage is enabled by defining RGB_FADER_GAMMA_EN.
module rgb_fader #(
    parameter int unsigned TICK_DIV = 1350000,
    parameter int unsigned STEP     = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       run,
    input  logic       restart,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       wrap
);

    localparam logic [23:0] LAST  = 24'(TICK_DIV - 1);
    localparam logic [8:0]  STEP9 = 9'(STEP);

    typedef enum logic [2:0] {
        G_UP = 3'd0,
        R_DN = 3'd1,
        B_UP = 3'd2,
        G_DN = 3'd3,
        R_UP = 3'd4,
        B_DN = 3'd5
    } state_t;

    logic        clear_s;
    logic [23:0] cnt_r;
    logic        tick_r;
    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  ch_r_r;
    logic [7:0]  ch_g_r;
    logic [7:0]  ch_b_r;
    logic        wrap_int_r;
    logic [7:0]  cur_s;
    logic        up_s;
    logic [8:0]  sum_s;
    logic [8:0]  diff_s;
    logic [7:0]  nxt_s;
    logic        done_s;

    assign clear_s = sys_rst | restart;

    // Prescaler: free-running divider producing a registered one-cycle tick.
    always_ff @(posedge sys_clk) begin
        if (clear_s) begin
            cnt_r  <= 24'd0;
            tick_r <= 1'b0;
        end else if (run) begin
            if (cnt_r == LAST) begin
                cnt_r  <= 24'd0;
                tick_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + 24'd1;
                tick_r <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    // Active channel selection and saturating 9-bit step arithmetic.
    always_comb begin
        cur_s        = 8'd0;
        up_s         = 1'b0;
        next_state_s = state_r;
        case (state_r)
            G_UP: begin cur_s = ch_g_r; up_s = 1'b1; next_state_s = R_DN; end
            R_DN: begin cur_s = ch_r_r; up_s = 1'b0; next_state_s = B_UP; end
            B_UP: begin cur_s = ch_b_r; up_s = 1'b1; next_state_s = G_DN; end
            G_DN: begin cur_s = ch_g_r; up_s = 1'b0; next_state_s = R_UP; end
            R_UP: begin cur_s = ch_r_r; up_s = 1'b1; next_state_s = B_DN; end
            B_DN: begin cur_s = ch_b_r; up_s = 1'b0; next_state_s = G_UP; end
            default: begin cur_s = 8'd0; up_s = 1'b0; next_state_s = G_UP; end
        endcase
        sum_s  = {1'b0, cur_s} + STEP9;
        diff_s = {1'b0, cur_s} - STEP9;
        if (up_s) begin
            nxt_s  = sum_s[8] ? 8'd255 : sum_s[7:0];
            done_s = (nxt_s == 8'd255);
        end else begin
            nxt_s  = diff_s[8] ? 8'd0 : diff_s[7:0];
            done_s = (nxt_s == 8'd0);
        end
    end

    // Hue FSM: updates the active channel on a tick and advances once it saturates.
    always_ff @(posedge sys_clk) begin
        if (clear_s) begin
            state_r    <= G_UP;
            ch_r_r     <= 8'd255;
            ch_g_r     <= 8'd0;
            ch_b_r     <= 8'd0;
            wrap_int_r <= 1'b0;
        end else if (tick_r) begin
            if (done_s) begin
                state_r <= next_state_s;
            end
            wrap_int_r <= done_s && (state_r == B_DN);
            case (state_r)
                G_UP, G_DN: ch_g_r  <= nxt_s;
                R_DN, R_UP: ch_r_r  <= nxt_s;
                B_UP, B_DN: ch_b_r  <= nxt_s;
                default:    state_r <= G_UP;
            endcase
        end else begin
            wrap_int_r <= 1'b0;
        end
    end

`ifdef RGB_FADER_GAMMA_EN
    // Approximate square-law curve; maps 0->0, 128->64 and 255->255.
    function automatic logic [7:0] gamma(input logic [7:0] v);
        logic [15:0] p;
        p = 16'(v) * 16'(v) + 16'(v);
        return p[15:8];
    endfunction

    logic [7:0] red_r;
    logic [7:0] green_r;
    logic [7:0] blue_r;
    logic       wrap_r;

    // Gamma pipeline stage; wrap is delayed alongside so it stays aligned with the colours.
    always_ff @(posedge sys_clk) begin
        if (clear_s) begin
            red_r   <= 8'd255;
            green_r <= 8'd0;
            blue_r  <= 8'd0;
            wrap_r  <= 1'b0;
        end else begin
            red_r   <= gamma(ch_r_r);
            green_r <= gamma(ch_g_r);
            blue_r  <= gamma(ch_b_r);
            wrap_r  <= wrap_int_r;
        end
    end

    assign red   = red_r;
    assign green = green_r;
    assign blue  = blue_r;
    assign wrap  = wrap_r;
`else
    assign red   = ch_r_r;
    assign green = ch_g_r;
    assign blue  = ch_b_r;
    assign wrap  = wrap_int_r;
`endif

endmodule

// File: tb/tb_rgb_fader.sv
// Directed bench for rgb_fader: three instances cover slow/unit-step, large-step and every-cycle tick.
// Gamma-specific checks are compiled when RGB_FADER_GAMMA_EN is defined.
module tb_rgb_fader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, run_a, restart_a, wrap_a;
    logic [7:0] red_a, green_a, blue_a;
    logic       rst_b, run_b, restart_b, wrap_b;
    logic [7:0] red_b, green_b, blue_b;
    logic       rst_c, run_c, restart_c, wrap_c;
    logic [7:0] red_c, green_c, blue_c;

    int checks = 0;
    int errors = 0;

    rgb_fader #(.TICK_DIV(4), .STEP(1)) u_a (
        .sys_clk(clk), .sys_rst(rst_a), .run(run_a), .restart(restart_a),
        .red(red_a), .green(green_a), .blue(blue_a), .wrap(wrap_a)
    );

    rgb_fader #(.TICK_DIV(4), .STEP(100)) u_b (
        .sys_clk(clk), .sys_rst(rst_b), .run(run_b), .restart(restart_b),
        .red(red_b), .green(green_b), .blue(blue_b), .wrap(wrap_b)
    );

    rgb_fader #(.TICK_DIV(1), .STEP(1)) u_c (
        .sys_clk(clk), .sys_rst(rst_c), .run(run_c), .restart(restart_c),
        .red(red_c), .green(green_c), .blue(blue_c), .wrap(wrap_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    int         wraps;
    int         wrap_edge;
    logic [7:0] wr, wg, wb;
    logic       found;
    logic [7:0] exp_g_b [8];
    logic [7:0] exp_r_b [8];
    logic [7:0] exp_bl_b[8];

    initial begin
        rst_a = 1'b1; run_a = 1'b1; restart_a = 1'b0;
        rst_b = 1'b1; run_b = 1'b1; restart_b = 1'b0;
        rst_c = 1'b1; run_c = 1'b1; restart_c = 1'b0;
        edges(2);

        chk("rst_red",   32'(red_a),   32'd255);
        chk("rst_green", 32'(green_a), 32'd0);
        chk("rst_blue",  32'(blue_a),  32'd0);
        chk("rst_wrap",  32'(wrap_a),  32'd0);

`ifdef RGB_FADER_GAMMA_EN
        rst_a = 1'b0; run_a = 1'b0;
        force u_a.ch_g_r = 8'd128;
        edges(1);
        chk("gamma_128", 32'(green_a), 32'd64);
        chk("gamma_255", 32'(red_a),   32'd255);
        chk("gamma_0",   32'(blue_a),  32'd0);
        release u_a.ch_g_r;
`else
        // Unit step, TICK_DIV=4: first step lands on the 5th edge after release.
        chk("rst_cnt", 32'(u_a.cnt_r), 32'd0);
        rst_a = 1'b0;
        edges(4);
        chk("g_edge4", 32'(green_a), 32'd0);
        edges(1);
        chk("g_edge5", 32'(green_a), 32'd1);
        edges(4);
        chk("g_edge9", 32'(green_a), 32'd2);
        edges(4);
        chk("g_edge13", 32'(green_a), 32'd3);
        chk("cnt_after_step", 32'(u_a.cnt_r), 32'd1);

        run_a = 1'b0;
        edges(10);
        chk("hold_green", 32'(green_a), 32'd3);
        chk("hold_cnt",   32'(u_a.cnt_r), 32'd1);
        chk("hold_red",   32'(red_a), 32'd255);
        run_a = 1'b1;
        edges(3);
        chk("resume_early", 32'(green_a), 32'd3);
        edges(1);
        chk("resume_step", 32'(green_a), 32'd4);

        // Mid-segment reset aborts and restarts the prescaler.
        edges(2);
        rst_a = 1'b1;
        edges(1);
        chk("midrst_green", 32'(green_a), 32'd0);
        chk("midrst_cnt",   32'(u_a.cnt_r), 32'd0);
        chk("midrst_wrap",  32'(wrap_a), 32'd0);
        rst_a = 1'b0;
        edges(4);
        chk("midrst_g4", 32'(green_a), 32'd0);
        edges(1);
        chk("midrst_g5", 32'(green_a), 32'd1);

        // STEP=100: saturating sequence across G_UP, R_DN and into B_UP.
        exp_g_b  = '{8'd100, 8'd200, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        exp_r_b  = '{8'd255, 8'd255, 8'd255, 8'd155, 8'd55,  8'd0,   8'd0,   8'd0};
        exp_bl_b = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd100, 8'd200};
        rst_b = 1'b0;
        edges(1);
        for (int i = 0; i < 8; i++) begin
            edges(4);
            chk($sformatf("step100_g%0d", i), 32'(green_b), 32'(exp_g_b[i]));
            chk($sformatf("step100_r%0d", i), 32'(red_b),   32'(exp_r_b[i]));
            chk($sformatf("step100_b%0d", i), 32'(blue_b),  32'(exp_bl_b[i]));
        end

        // TICK_DIV=1: one full hue cycle is 1530 steps; the wrap lands on edge 1531.
        wraps = 0; wrap_edge = 0; wr = 8'd0; wg = 8'd0; wb = 8'd0;
        rst_c = 1'b0;
        for (int e = 1; e <= 1535; e++) begin
            edges(1);
            if (wrap_c === 1'b1) begin
                wraps++;
                wrap_edge = e;
                wr = red_c; wg = green_c; wb = blue_c;
            end
        end
        chk("wrap_count", 32'(wraps),     32'd1);
        chk("wrap_edge",  32'(wrap_edge), 32'd1531);
        chk("wrap_red",   32'(wr), 32'd255);
        chk("wrap_green", 32'(wg), 32'd0);
        chk("wrap_blue",  32'(wb), 32'd0);
        chk("post_wrap_green", 32'(green_c), 32'd4);

        // Restart coinciding with a tick in R_UP wins over the step.
        found = 1'b0;
        for (int e = 0; e < 3000 && !found; e++) begin
            edges(1);
            if (red_c == 8'd100 && green_c == 8'd0 && blue_c == 8'd255) found = 1'b1;
        end
        chk("rup_reached", 32'(found), 32'd1);
        restart_c = 1'b1;
        edges(1);
        restart_c = 1'b0;
        chk("restart_red",   32'(red_c),   32'd255);
        chk("restart_green", 32'(green_c), 32'd0);
        chk("restart_blue",  32'(blue_c),  32'd0);
        chk("restart_wrap",  32'(wrap_c),  32'd0);
        edges(1);
        chk("restart_g1", 32'(green_c), 32'd0);
        edges(1);
        chk("restart_g2", 32'(green_c), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_fader.md
RGB_FADER -- requirements
Module: rgb_fader

Interface
REQ-001 Parameter TICK_DIV, default 1350000: sys_clk cycles per colour step (0.05 s at 27 MHz); legal range 1..2^24-1.
REQ-002 Parameter STEP, default 1: per-tick increment/decrement applied to the active channel; legal range 1..255.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  synchronous, active-high reset.
REQ-005 run  input  1  1 = prescaler advances; 0 = prescaler and colour state hold.
REQ-006 restart  input  1  single-cycle synchronous return to reset values.
REQ-007 red  output  8  red duty value for the downstream pwm threshold.
REQ-008 green  output  8  green duty value for the downstream pwm threshold.
REQ-009 blue  output  8  blue duty value for the downstream pwm threshold.
REQ-010 wrap  output  1  one-cycle pulse on completion of a full hue cycle.

Function
REQ-011 Prescaler: 24-bit counter increments while run=1; at value TICK_DIV-1 it SHALL produce an internal tick and load 0, giving one tick every TICK_DIV cycles.
REQ-012 With run=0 the counter SHALL hold its value and no tick SHALL occur, even if the counter equals TICK_DIV-1.
REQ-013 FSM states, in order: G_UP, R_DN, B_UP, G_DN, R_UP, B_DN; only the active channel changes, and only on a tick.
REQ-014 UP states: channel <= min(channel+STEP, 255), using 9-bit intermediate arithmetic with no 8-bit wrap; DN states: channel <= max(channel-STEP, 0).
REQ-015 When the updated channel reaches 255 (UP) or 0 (DN), the FSM SHALL move to the next state on the same edge; the next tick then acts on the new channel.
REQ-016 Transition list: G_UP->R_DN, R_DN->B_UP, B_UP->G_DN, G_DN->R_UP, R_UP->B_DN, B_DN->G_UP.
REQ-017 On the B_DN->G_UP transition, wrap SHALL be 1 for exactly one cycle, aligned with the output update that sets blue to 0.
REQ-018 red, green and blue SHALL be registered; with the gamma stage compiled out, their latency from tick to output change SHALL be 1 cycle.
REQ-019 Priority: sys_rst > restart > tick; if restart and tick coincide, restart wins and no step is applied.
REQ-020 restart SHALL load the same values as reset into counter, FSM, channels and wrap; run is ignored that cycle.

Reset
REQ-021 With sys_rst=1 at a clock edge: counter=0, state=G_UP, red=255, green=0, blue=0, wrap=0; the gamma pipeline register, if present, SHALL hold the gamma of (255,0,0), i.e. (255,0,0).
REQ-022 Asserting sys_rst mid-segment SHALL abort the segment with no partial step or wrap pulse; the first tick after release occurs TICK_DIV cycles after the first edge with sys_rst=0 and run=1.

Configuration
REQ-023 Macro RGB_FADER_GAMMA_EN defined: each output SHALL be (v*v+v)>>8 of its internal channel v, through one extra register stage; wrap SHALL be delayed by one cycle to stay aligned, giving a total tick-to-output latency of 2 cycles.
REQ-024 Macro undefined: outputs SHALL equal the internal channels directly, with no extra stage and no multiplier inferred.
REQ-025 The gamma mapping SHALL satisfy 0->0, 128->64 and 255->255.

Verification (TICK_DIV=4, STEP=1, gamma off unless stated)
REQ-026 Assert sys_rst for 2 cycles with run=1 -> red=255, green=0, blue=0, wrap=0; after release, green=1 at the 5th edge (tick on the 4th edge, output 1 cycle later), then +1 every 4 cycles.
REQ-027 STEP=100 -> green sequence 0,100,200,255, then state R_DN with red 155,55,0, then blue 100...; no value ever exceeds 255 or underflows.
REQ-028 TICK_DIV=1, STEP=1, run=1 -> exactly one wrap pulse after 1530 ticks, with outputs (255,0,0) in that cycle, and no other wrap pulse in the interval.
REQ-029 Drop run for 10 cycles mid-G_UP -> outputs and counter frozen; on resume, the next tick arrives after the remaining counter cycles.
REQ-030 restart pulsed in the same cycle as a tick while in R_UP -> next cycle outputs (255,0,0), no step applied, no wrap pulse.
REQ-031 RGB_FADER_GAMMA_EN defined, force internal green=128 -> green output=64 two cycles after the tick; reset outputs read (255,0,0).
